// File: rtl/tts_pkg.sv
// Shared definitions for the strategy host message protocol: command/result
// codes, RCB RAM encoding and the 32-byte host message layout.
package tts_pkg;

  localparam logic [7:0] CMD_RD_RSP  = 8'h81;
  localparam logic [7:0] RES_OK      = 8'h00;
  localparam logic [7:0] RES_RCB_ERR = 8'h01;
  localparam logic [7:0] RES_BAD_RAM = 8'h02;

  typedef enum logic [7:0] {
    RAM_SRCB = 8'h01,
    RAM_PRCB = 8'h02,
    RAM_VRCB = 8'h04,
    RAM_ORCB = 8'h08
  } t_RAM_ENCODING;

  // First field lands in the most significant bits, i.e. the first wire byte.
  typedef struct packed {
    logic [7:0]   cmd;
    logic [7:0]   ram;
    logic [15:0]  addr;
    logic [7:0]   res;
    logic [23:0]  byte_en;
    logic [191:0] data;
  } t_host_rsp_map;

  function automatic logic ram_is_valid(input logic [7:0] ram);
    case (ram)
      RAM_SRCB, RAM_PRCB, RAM_VRCB, RAM_ORCB: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tts_msg_serializer.sv
// Loads a 4-beat message and shifts it out MSB-first on a valid/ready stream,
// reloading on the last beat's transfer so back-to-back messages have no bubble.
module tts_msg_serializer #(
  parameter int BEAT_W = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*BEAT_W-1:0]   load_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [BEAT_W-1:0]     tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  msg_done
);

  typedef enum logic {S_IDLE, S_SEND} t_state;

  t_state              state;
  logic [1:0]          beat;
  logic [4*BEAT_W-1:0] shreg;

  assign tx_data    = shreg[4*BEAT_W-1 -: BEAT_W];
  assign msg_done   = tx_valid && tx_ready && tx_eop;
  assign load_ready = reset_n &&
                      ((state == S_IDLE) || (state == S_SEND && beat == 2'd3 && tx_ready));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      beat     <= '0;
      shreg    <= '0;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
    end else if (load_valid && load_ready) begin
      state    <= S_SEND;
      beat     <= '0;
      shreg    <= load_data;
      tx_valid <= 1'b1;
      tx_sop   <= 1'b1;
      tx_eop   <= 1'b0;
    end else if (state == S_SEND && tx_ready) begin
      if (beat == 2'd3) begin
        state    <= S_IDLE;
        beat     <= '0;
        shreg    <= '0;
        tx_valid <= 1'b0;
        tx_sop   <= 1'b0;
        tx_eop   <= 1'b0;
      end else begin
        beat   <= beat + 2'd1;
        shreg  <= shreg << BEAT_W;
        tx_sop <= 1'b0;
        tx_eop <= (beat == 2'd2);
      end
    end
  end

endmodule

// File: rtl/tts_host_rsp_tx.sv
// Host-bound read-response transmitter: validates and packs RCB read responses
// into 32-byte host messages and streams them as four 64-bit beats.
module tts_host_rsp_tx #(
  parameter int         TX_W       = 64,
  parameter logic [7:0] CMD_RD_RSP = tts_pkg::CMD_RD_RSP,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [7:0]       rsp_ram,
  input  logic [15:0]      rsp_addr,
  input  logic [23:0]      rsp_byte_en,
  input  logic [191:0]     rsp_data,
  input  logic             rsp_err,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [TX_W-1:0]  tx_data,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [CNT_W-1:0] msg_cnt
);

  import tts_pkg::*;

  t_host_rsp_map msg;
  logic          msg_done;

  // Bad RAM encoding outranks an RCB error; any failure blanks the data field.
  always_comb begin
    msg         = '0;
    msg.cmd     = CMD_RD_RSP;
    msg.ram     = rsp_ram;
    msg.addr    = rsp_addr;
    msg.byte_en = rsp_byte_en;
    if (!ram_is_valid(rsp_ram)) msg.res = RES_BAD_RAM;
    else if (rsp_err)           msg.res = RES_RCB_ERR;
    else                        msg.res = RES_OK;
    msg.data    = (msg.res == RES_OK) ? rsp_data : '0;
  end

  tts_msg_serializer #(
    .BEAT_W (TX_W)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (rsp_valid),
    .load_ready (rsp_ready),
    .load_data  (msg),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .msg_done   (msg_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)      msg_cnt <= '0;
    else if (msg_done) msg_cnt <= msg_cnt + 1'b1;
  end

endmodule

// File: tb/tb_tts_host_rsp_tx.sv
// Scoreboard bench for tts_host_rsp_tx: the driver queues expected beats per
// response, a negedge monitor pops and compares every transferred beat.
module tb_tts_host_rsp_tx;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         rsp_valid;
  logic         rsp_ready, rsp_ready_w;
  logic [7:0]   rsp_ram;
  logic [15:0]  rsp_addr;
  logic [23:0]  rsp_byte_en;
  logic [191:0] rsp_data;
  logic         rsp_err;
  logic         tx_valid, tx_valid_w;
  logic         tx_ready;
  logic [63:0]  tx_data, tx_data_w;
  logic         tx_sop, tx_sop_w, tx_eop, tx_eop_w;
  logic [15:0]  msg_cnt;
  logic [3:0]   msg_cnt_w;

  always #5 clk = ~clk;

  tts_host_rsp_tx #(.TX_W(64), .CMD_RD_RSP(8'h81), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ram(rsp_ram), .rsp_addr(rsp_addr), .rsp_byte_en(rsp_byte_en),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .msg_cnt(msg_cnt)
  );

  // Narrow-counter copy fed identically, used only for the wrap check.
  tts_host_rsp_tx #(.TX_W(64), .CMD_RD_RSP(8'h81), .CNT_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready_w),
    .rsp_ram(rsp_ram), .rsp_addr(rsp_addr), .rsp_byte_en(rsp_byte_en),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .tx_valid(tx_valid_w), .tx_ready(tx_ready),
    .tx_data(tx_data_w), .tx_sop(tx_sop_w), .tx_eop(tx_eop_w), .msg_cnt(msg_cnt_w)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t        exp_q[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic         bp_mode = 1'b0;
  logic         check_gap = 1'b0;
  int unsigned  idle_cnt = 0;

  logic         prev_stall = 1'b0;
  logic [63:0]  prev_data;
  logic         prev_sop, prev_eop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic [7:0] ram, input logic [15:0] addr,
                          input logic [23:0] be, input logic [191:0] data,
                          input logic [7:0] res);
    beat_t        b;
    logic [191:0] d;
    d      = (res != 8'h00) ? '0 : data;
    b.data = {8'h81, ram, addr, res, be};
    b.sop  = 1'b1;
    b.eop  = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < 3; i++) begin
      b.data = d[191-64*i -: 64];
      b.sop  = 1'b0;
      b.eop  = (i == 2);
      exp_q.push_back(b);
    end
  endtask

  // res is the hand-derived result code for this vector.
  task automatic send(input logic [7:0] ram, input logic [15:0] addr,
                      input logic [23:0] be, input logic [191:0] data,
                      input logic err, input logic [7:0] res);
    logic ok;
    push_msg(ram, addr, be, data, res);
    rsp_ram     = ram;
    rsp_addr    = addr;
    rsp_byte_en = be;
    rsp_data    = data;
    rsp_err     = err;
    rsp_valid   = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: got rsp_ready=0 for 200 cycles expected 1");
    end
    @(posedge clk);
    #1 rsp_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_sop_eop", {tx_sop, tx_eop}, 2'b00);
    check("rst_tx_data", tx_data, 64'h0);
    check("rst_msg_cnt", msg_cnt, 16'h0);
    check("rst_rsp_ready", rsp_ready, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode) tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1'b1);
        check("hold_data", tx_data, prev_data);
        check("hold_sop_eop", {tx_sop, tx_eop}, {prev_sop, prev_eop});
      end
      if (tx_valid) begin
        check("rsp_ready_send", rsp_ready,
              (exp_q.size() > 0) && exp_q[0].eop && tx_ready);
        if (tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_beat: got beat %h expected none", tx_data);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", tx_data, e.data);
            check("beat_sop_eop", {tx_sop, tx_eop}, {e.sop, e.eop});
          end
        end
      end else begin
        check("rsp_ready_idle", rsp_ready, 1'b1);
        if (check_gap) idle_cnt++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_sop   = tx_sop;
      prev_eop   = tx_eop;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [191:0] d_seq;
    for (int i = 0; i < 24; i++) d_seq[191-8*i -: 8] = i[7:0];

    reset_n     = 1'b0;
    rsp_valid   = 1'b0;
    rsp_ram     = '0;
    rsp_addr    = '0;
    rsp_byte_en = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    tx_ready    = 1'b1;
    do_reset();

    // Single read: beat 0 one cycle after accept, hand-computed header and data.
    send(8'h02, 16'h1234, 24'hFFFFFF, d_seq, 1'b0, 8'h00);
    @(negedge clk);
    check("lat_valid", tx_valid, 1'b1);
    check("lat_sop", tx_sop, 1'b1);
    check("beat0_const", tx_data, 64'h8102_1234_00FF_FFFF);
    @(negedge clk);
    check("beat1_const", tx_data, 64'h0001_0203_0405_0607);
    drain();
    check("cnt_single", msg_cnt, 16'd1);

    // Back-to-back: 12 beats with no idle cycle.
    do_reset();
    send(8'h01, 16'h0001, 24'h000001, d_seq, 1'b0, 8'h00);
    idle_cnt  = 0;
    check_gap = 1'b1;
    send(8'h04, 16'hBEEF, 24'h123456, ~d_seq, 1'b0, 8'h00);
    send(8'h08, 16'hFFFF, 24'h000000, {d_seq[95:0], d_seq[191:96]}, 1'b0, 8'h00);
    drain();
    check_gap = 1'b0;
    check("b2b_idle", idle_cnt, 0);
    check("cnt_b2b", msg_cnt, 16'd3);

    // Error encodings: bad RAM outranks rcb error; data blanked.
    send(8'h03, 16'h0010, 24'hABCDEF, d_seq, 1'b0, 8'h02);
    send(8'h08, 16'h0020, 24'h00FF00, d_seq, 1'b1, 8'h01);
    send(8'h03, 16'h0030, 24'hFF00FF, d_seq, 1'b1, 8'h02);
    send(8'h00, 16'h0040, 24'h111111, d_seq, 1'b0, 8'h02);
    drain();
    check("cnt_err", msg_cnt, 16'd7);

    // Random back-pressure.
    bp_mode = 1'b1;
    send(8'h01, 16'hA001, 24'hFFFFFF, d_seq ^ {8{24'h5A5A5A}}, 1'b0, 8'h00);
    send(8'h04, 16'hA002, 24'h0F0F0F, ~d_seq, 1'b0, 8'h00);
    send(8'h08, 16'hA003, 24'hF0F0F0, d_seq, 1'b0, 8'h00);
    send(8'h02, 16'hA004, 24'h800001, {24{8'hC3}}, 1'b0, 8'h00);
    drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #2 tx_ready = 1'b1;
    check("cnt_bp", msg_cnt, 16'd11);

    // Reset during beat 2 discards the partial message.
    send(8'h01, 16'hABCD, 24'h00F0F0, d_seq, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", tx_valid, 1'b0);
    check("midrst_cnt", msg_cnt, 16'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(8'h04, 16'h5678, 24'h0A0B0C, ~d_seq, 1'b0, 8'h00);
    drain();
    check("cnt_post_rst", msg_cnt, 16'd1);

    // 17 messages: 4-bit counter wraps to 1.
    do_reset();
    for (int m = 0; m < 17; m++)
      send(8'h02, 16'(m), 24'hFFFFFF, d_seq, 1'b0, 8'h00);
    drain();
    check("cnt_wrap4", msg_cnt_w, 4'd1);
    check("cnt_17", msg_cnt, 16'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tts_host_rsp_tx.md
Name: tts_host_rsp_tx

Overview:
- Transmit end of the strategy host message protocol.
- Accepts read responses returned by the strategy RCBs: Symbol, Price, Volume and Order.
- Packs each response into the 32-byte host message layout: cmd, ram, addr, res, byte_en, data.
- Serializes the message as four 64-bit beats on a valid/ready stream toward the host interface, alongside the inbound host-command decode path.

Parameters:
- TX_W, 64, stream data width in bits; fixed at 64, message is exactly 4 beats.
- CMD_RD_RSP, 8'h81, cmd byte placed in every read-response message.
- CNT_W, 16, width of the transmitted-message counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- rsp_valid  in  1  RCB read response valid
- rsp_ready  out  1  response accepted when rsp_valid && rsp_ready
- rsp_ram  in  8  RAM encoding: SRCB=1, PRCB=2, VRCB=4, ORCB=8
- rsp_addr  in  16  RCB address read
- rsp_byte_en  in  24  byte enables echoed from the request
- rsp_data  in  192  read data; byte 0 = [191:184]
- rsp_err  in  1  RCB flagged the read as failed
- tx_valid  out  1  beat valid
- tx_ready  in  1  host-side back-pressure
- tx_data  out  64  beat data; first wire byte in [63:56]
- tx_sop  out  1  first beat of message
- tx_eop  out  1  last (4th) beat of message
- msg_cnt  out  CNT_W  messages fully transmitted; wraps modulo 2^CNT_W

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. While reset_n=0:
  - tx_valid, tx_sop, tx_eop = 0; tx_data = 0; msg_cnt = 0.
  - rsp_ready = 0.
  - FSM = IDLE; beat counter = 0.
- FSM states:
  - IDLE: rsp_ready=1, tx_valid=0. On rsp_valid, capture into the 256-bit message register and go to SEND, beat=0.
  - SEND: tx_valid=1, beat = beat counter (0..3). Advance the beat only when tx_valid && tx_ready.
  - On transfer of beat 3:
    - msg_cnt increments.
    - If rsp_valid is also high that cycle, capture the new message and stay in SEND with beat=0 (back-to-back, no bubble).
    - Otherwise go to IDLE.
- rsp_ready:
  - 1 in IDLE.
  - In SEND, equals (beat==3 && tx_ready), combinational from tx_ready.
  - 0 otherwise.
- Latency: beat 0 is presented the cycle after the response is accepted.
- Throughput: 1 message per 4 cycles with tx_ready held high.
- Packing, big-endian byte order:
  - Beat 0: cmd=CMD_RD_RSP, ram, addr[15:8], addr[7:0], res, byte_en[23:16], byte_en[15:8], byte_en[7:0].
  - Beats 1..3: data bytes 0-7, 8-15, 16-23.
- res byte, evaluated at capture, in priority order:
  - 8'h02 if rsp_ram is not exactly one of {1,2,4,8}.
  - Else 8'h01 if rsp_err=1.
  - Else 8'h00.
  - The message is still sent in all cases.
  - When res is nonzero, the data field is sent as zero; byte_en is echoed unchanged.
- Holding rules:
  - tx_sop = (beat==0); tx_eop = (beat==3).
  - While tx_valid && !tx_ready, tx_data, tx_sop and tx_eop hold stable.
  - tx_valid never drops before its beat transfers.
- msg_cnt wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Reset mid-message: the partial message is discarded. tx_valid=0 in the cycle following the reset edge, and no eop is sent for the discarded message.
- No internal FIFO; the source is back-pressured via rsp_ready.

Decomposition:
- Into tts_pkg:
  - CMD_RD_RSP and the res codes: RES_OK=8'h00, RES_RCB_ERR=8'h01, RES_BAD_RAM=8'h02.
  - t_RAM_ENCODING.
  - A response struct t_host_rsp_map with exact widths: cmd 8, ram 8, addr 16, res 8, byte_en 24, data 192, totalling 256 bits.
- Sub-module tts_msg_serializer: generic 256-bit load / 4x64-bit valid/ready shifter with sop/eop and a load-on-last-beat path. The top holds validation, res encoding and the counter.

Test Plan:
- Single read, tx_ready=1: ram=8'h02, addr=16'h1234, be=24'hFFFFFF, data=192'h00_01..17 (byte i = i).
  - 4 beats starting 1 cycle after accept.
  - Beat0 = 64'h81_02_12_34_00_FF_FF_FF.
  - Beat1 = 64'h0001020304050607, sop on beat0, eop on beat3.
  - msg_cnt = 1.
- Back-to-back: 3 responses presented continuously with tx_ready=1.
  - 12 contiguous beats with no idle cycle.
  - rsp_ready pulses only with beat 3.
  - msg_cnt = 3.
- Back-pressure: toggle tx_ready randomly at 50%.
  - Beats hold stable while stalled; no beat is lost or duplicated.
  - Payload matches the scoreboard; rsp_ready stays 0 until beat 3 transfers.
- Errors:
  - ram=8'h03 -> beat0 res byte = 8'h02, data beats all zero.
  - ram=8'h08 with rsp_err=1 -> res = 8'h01.
  - ram=8'h03 with rsp_err=1 -> res = 8'h02 (priority).
- Reset mid-message: assert reset_n=0 during beat 2.
  - tx_valid=0 and msg_cnt=0 next cycle.
  - A post-reset response is transmitted intact starting with sop.
- Counter wrap: force CNT_W=4 and send 17 messages -> msg_cnt reads 1.
